// File: rtl/program_sequencer.sv
// program_sequencer
//   Holds a short program in an internal word buffer and feeds it to the processor
//   one instruction at a time. Each instruction gets a one-cycle run pulse, and the
//   sequencer waits for done before it moves on. An mvi instruction carries its
//   immediate in the following word, which is presented on dout the cycle after the
//   run pulse. A watchdog flags a processor that never completes an instruction.
// Ports
//   i_clk        rising-edge clock
//   i_reset      asynchronous active-high reset
//   i_load_en    buffer write strobe (accepted in idle only)
//   i_load_addr  buffer write address
//   i_load_data  buffer write data
//   i_prog_len   number of words to execute, sampled on start (capped at DEPTH)
//   i_start      run the program from address 0, or clear a pending error
//   o_dout       word presented to the processor Din
//   o_run        one-cycle pulse per issued instruction
//   i_done       instruction complete, from the processor
//   o_busy       program in progress
//   o_finished   one-cycle pulse when the last instruction completes
//   o_error      sticky watchdog / truncated-immediate flag, cleared by start
module program_sequencer #(
  parameter int unsigned WORD    = 16,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned AW      = 5,
  parameter logic [2:0]  MVI_OP  = 3'b001,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_load_en,
  input  logic [AW-1:0]   i_load_addr,
  input  logic [WORD-1:0] i_load_data,
  input  logic [AW:0]     i_prog_len,
  input  logic            i_start,
  output logic [WORD-1:0] o_dout,
  output logic            o_run,
  input  logic            i_done,
  output logic            o_busy,
  output logic            o_finished,
  output logic            o_error
);

  localparam int unsigned    WDW     = $clog2(TIMEOUT) + 1;
  localparam logic [AW:0]    DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StImm, StWait, StFinish, StError} state_e;

  state_e          r_state;
  logic [AW-1:0]   r_pc;
  logic [AW:0]     r_len;
  logic [WDW-1:0]  r_wdog;
  logic [WORD-1:0] r_dout;
  logic            r_run;
  logic            r_busy;
  logic            r_finished;
  logic            r_error;
  logic [WORD-1:0] r_mem [DEPTH];

  logic [AW-1:0]   w_pc_inc;
  logic            w_last;
  logic            w_is_mvi;
  logic [AW:0]     w_len_cap;
  logic [WORD-1:0] w_mem_next;

  assign w_pc_inc   = r_pc + 1'b1;
  // Widened compare so pc+1 == DEPTH is representable.
  assign w_last     = (({1'b0, r_pc} + 1'b1) == r_len);
  // In ISSUE r_dout already holds mem[pc], so the opcode is decoded from it.
  assign w_is_mvi   = (r_dout[8:6] == MVI_OP);
  assign w_len_cap  = (i_prog_len > DEPTH_L) ? DEPTH_L : i_prog_len;
  assign w_mem_next = r_mem[w_pc_inc];

  assign o_dout     = r_dout;
  assign o_run      = r_run;
  assign o_busy     = r_busy;
  assign o_finished = r_finished;
  assign o_error    = r_error;

  // Program buffer: not reset, so a program survives a mid-run reset.
  always_ff @(posedge i_clk) begin
    if (r_state == StIdle && i_load_en) begin
      r_mem[i_load_addr] <= i_load_data;
    end
  end

  // Outputs are registered alongside the state they belong to: every transition
  // loads the output values that the destination state presents.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_pc       <= '0;
      r_len      <= '0;
      r_wdog     <= '0;
      r_dout     <= '0;
      r_run      <= 1'b0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_run      <= 1'b0;
      r_finished <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            if (i_prog_len == '0) begin
              r_state    <= StFinish;
              r_finished <= 1'b1;
            end else begin
              r_len   <= w_len_cap;
              r_pc    <= '0;
              r_wdog  <= '0;
              r_dout  <= r_mem[0];
              r_run   <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= StIssue;
            end
          end
        end
        StIssue: begin
          // The watchdog counts from the run pulse, so ISSUE is its first cycle.
          r_wdog <= r_wdog + 1'b1;
          if (w_is_mvi) begin
            if (w_last) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= StError;
            end else begin
              r_pc    <= w_pc_inc;
              r_dout  <= w_mem_next;
              r_state <= StImm;
            end
          end else begin
            r_state <= StWait;
          end
        end
        StImm, StWait: begin
          if (i_done) begin
            if (w_last) begin
              r_finished <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= StFinish;
            end else begin
              r_pc    <= w_pc_inc;
              r_dout  <= w_mem_next;
              r_run   <= 1'b1;
              r_wdog  <= '0;
              r_state <= StIssue;
            end
          end else if (r_wdog == WD_LAST) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StError;
          end else begin
            r_wdog  <= r_wdog + 1'b1;
            r_state <= StWait;
          end
        end
        StFinish: begin
          r_state <= StIdle;
        end
        StError: begin
          if (i_start) begin
            r_error <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer. Each vector row is applied for one clock
// edge and the registered outputs are compared at the following falling edge.
module tb_program_sequencer;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [15:0] load_data;
  logic [5:0]  prog_len;
  logic        start;
  logic        done;
  logic [15:0] dout;
  logic        run;
  logic        busy;
  logic        finished;
  logic        error;

  int n_checks;
  int n_errors;

  program_sequencer dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_load_en   (load_en),
    .i_load_addr (load_addr),
    .i_load_data (load_data),
    .i_prog_len  (prog_len),
    .i_start     (start),
    .o_dout      (dout),
    .o_run       (run),
    .i_done      (done),
    .o_busy      (busy),
    .o_finished  (finished),
    .o_error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        done;
    logic        load_en;
    logic [4:0]  addr;
    logic [15:0] data;
    logic [5:0]  len;
    logic        run;
    logic [15:0] dout;
    logic        busy;
    logic        fin;
    logic        err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic st, logic dn, logic ld, logic [4:0] a, logic [15:0] d,
                              logic [5:0] ln, logic xr, logic [15:0] xd, logic xb,
                              logic xf, logic xe);
    vec_t v;
    v.start = st; v.done = dn; v.load_en = ld; v.addr = a; v.data = d; v.len = ln;
    v.run = xr; v.dout = xd; v.busy = xb; v.fin = xf; v.err = xe;
    return v;
  endfunction

  // Plain step: start/done/len inputs, expected run/dout/busy/finished/error.
  task automatic row(logic st, logic dn, logic [5:0] ln, logic xr, logic [15:0] xd,
                     logic xb, logic xf, logic xe);
    vq.push_back(mk(st, dn, 1'b0, 5'd0, 16'h0, ln, xr, xd, xb, xf, xe));
  endtask

  // Buffer write while not busy; outputs are expected to stay put.
  task automatic ld(logic [4:0] a, logic [15:0] d, logic [15:0] xd, logic xe);
    vq.push_back(mk(1'b0, 1'b0, 1'b1, a, d, 6'd0, 1'b0, xd, 1'b0, 1'b0, xe));
  endtask

  task automatic check_out(string name, logic xr, logic [15:0] xd, logic xb, logic xf,
                           logic xe);
    n_checks++;
    if ({run, dout, busy, finished, error} !== {xr, xd, xb, xf, xe}) begin
      n_errors++;
      $display("FAIL %s: got run=%b dout=%h busy=%b fin=%b err=%b, want run=%b dout=%h busy=%b fin=%b err=%b",
               name, run, dout, busy, finished, error, xr, xd, xb, xf, xe);
    end
  endtask

  task automatic apply(string tag, int idx, vec_t v);
    start = v.start; done = v.done; load_en = v.load_en;
    load_addr = v.addr; load_data = v.data; prog_len = v.len;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; done = 1'b0; load_en = 1'b0;
    check_out($sformatf("%s[%0d]", tag, idx), v.run, v.dout, v.busy, v.fin, v.err);
  endtask

  task automatic run_queue(string tag);
    foreach (vq[i]) apply(tag, i, vq[i]);
    vq.delete();
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    prog_len = '0; start = 1'b0; done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_out("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // T1: mv R0,R1 ; add R2,R3, done two cycles after each run, start while busy
    ld(5'd0, 16'h0001, 16'h0000, 1'b0);
    ld(5'd1, 16'h0093, 16'h0000, 1'b0);
    row(1, 0, 6'd2, 1, 16'h0001, 1, 0, 0);
    row(0, 0, 6'd2, 0, 16'h0001, 1, 0, 0);
    row(0, 0, 6'd2, 0, 16'h0001, 1, 0, 0);
    row(0, 1, 6'd2, 1, 16'h0093, 1, 0, 0);
    row(1, 0, 6'd2, 0, 16'h0093, 1, 0, 0);
    row(0, 0, 6'd2, 0, 16'h0093, 1, 0, 0);
    row(0, 1, 6'd2, 0, 16'h0093, 0, 1, 0);
    row(0, 0, 6'd2, 0, 16'h0093, 0, 0, 0);
    // T5: empty program finishes without a run
    row(1, 0, 6'd0, 0, 16'h0093, 0, 1, 0);
    row(0, 0, 6'd0, 0, 16'h0093, 0, 0, 0);
    // T2: mvi R0 with immediate, done during the immediate cycle
    ld(5'd0, 16'h0040, 16'h0093, 1'b0);
    ld(5'd1, 16'h00A5, 16'h0093, 1'b0);
    row(1, 0, 6'd2, 1, 16'h0040, 1, 0, 0);
    row(0, 0, 6'd2, 0, 16'h00A5, 1, 0, 0);
    row(0, 1, 6'd2, 0, 16'h00A5, 0, 1, 0);
    row(0, 0, 6'd2, 0, 16'h00A5, 0, 0, 0);
    // T3: truncated mvi; load in error ignored; start only clears
    row(1, 0, 6'd1, 1, 16'h0040, 1, 0, 0);
    row(0, 0, 6'd1, 0, 16'h0040, 0, 0, 1);
    ld(5'd0, 16'h0001, 16'h0040, 1'b1);
    row(0, 0, 6'd1, 0, 16'h0040, 0, 0, 1);
    row(1, 0, 6'd1, 0, 16'h0040, 0, 0, 0);
    row(0, 0, 6'd1, 0, 16'h0040, 0, 0, 0);
    row(1, 0, 6'd1, 1, 16'h0040, 1, 0, 0);
    row(0, 0, 6'd1, 0, 16'h0040, 0, 0, 1);
    row(1, 0, 6'd1, 0, 16'h0040, 0, 0, 0);
    // T4: done never arrives; error appears 64 cycles after the run pulse
    ld(5'd0, 16'h0001, 16'h0040, 1'b0);
    row(1, 0, 6'd1, 1, 16'h0001, 1, 0, 0);
    for (int i = 0; i < 63; i++) row(0, 0, 6'd1, 0, 16'h0001, 1, 0, 0);
    row(0, 0, 6'd1, 0, 16'h0001, 0, 0, 1);
    row(0, 0, 6'd1, 0, 16'h0001, 0, 0, 1);
    row(1, 0, 6'd1, 0, 16'h0001, 0, 0, 0);
    run_queue("vec");

    // T6: three-instruction program, reset during the first WAIT
    ld(5'd0, 16'h0001, 16'h0001, 1'b0);
    ld(5'd1, 16'h0093, 16'h0001, 1'b0);
    ld(5'd2, 16'h00CA, 16'h0001, 1'b0);
    row(1, 0, 6'd3, 1, 16'h0001, 1, 0, 0);
    row(0, 0, 6'd3, 0, 16'h0001, 1, 0, 0);
    run_queue("t6a");
    #2 reset = 1'b1;
    #1 check_out("async_reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_out("after_reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Rerun without reloading; busy-time load/start and ISSUE-time done are ignored
    row(1, 0, 6'd3, 1, 16'h0001, 1, 0, 0);
    vq.push_back(mk(1'b1, 1'b0, 1'b1, 5'd2, 16'hFFFF, 6'd3, 1'b0, 16'h0001, 1'b1, 1'b0,
                    1'b0));
    row(1, 1, 6'd3, 1, 16'h0093, 1, 0, 0);
    row(0, 1, 6'd3, 0, 16'h0093, 1, 0, 0);
    row(0, 1, 6'd3, 1, 16'h00CA, 1, 0, 0);
    row(0, 0, 6'd3, 0, 16'h00CA, 1, 0, 0);
    row(0, 1, 6'd3, 0, 16'h00CA, 0, 1, 0);
    row(0, 0, 6'd3, 0, 16'h00CA, 0, 0, 0);
    run_queue("t6b");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
